// File: rtl/rtc_pkg.sv
// Shared types and BCD limits for the RTC time-setting front end.
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    COMMIT = 2'd3
  } rtc_state_e;

  typedef struct packed {
    rtc_state_e state;
    logic       mode_level;
    logic       inc_level;
  } rtc_dbg_t;

  localparam logic [1:0] HOURS_TENS_MAX = 2'd2;
  localparam int         HOURS_MAX      = 23;
  localparam logic [3:0] MIN_TENS_MAX   = 4'd5;
  localparam logic [3:0] DIGIT_MAX      = 4'd9;

  // Returns {tens, ones}; 23 wraps to 00, a ones digit of 9 carries into tens.
  function automatic logic [5:0] inc_hours(input logic [1:0] h10, input logic [3:0] h1);
    if ((int'(h10) * 10 + int'(h1)) == HOURS_MAX) return 6'd0;
    if (h1 == DIGIT_MAX) return {h10 + 2'd1, 4'd0};
    return {h10, h1 + 4'd1};
  endfunction

  // Returns {tens, ones}; 59 wraps to 00 with no carry out.
  function automatic logic [7:0] inc_minutes(input logic [3:0] m10, input logic [3:0] m1);
    if (m1 != DIGIT_MAX) return {m10, m1 + 4'd1};
    if (m10 == MIN_TENS_MAX) return 8'd0;
    return {m10 + 4'd1, 4'd0};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: 2-FF synchronizer, stability counter and a one-cycle
// pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q, level_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // Any sample equal to the accepted level restarts the stability count.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        press_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
endmodule

// File: rtl/rtc_time_set.sv
// Button-driven hours/minutes editor with blink mask and valid/ready load.
// Optional auto-repeat on a held INC button: define RTC_SET_AUTOREPEAT_EN.
module rtc_time_set
  import rtc_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_S       = 30
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic [1:0] cur_hours_10_i,
  input  logic [3:0] cur_hours_1_i,
  input  logic [3:0] cur_minutes_10_i,
  input  logic [3:0] cur_minutes_1_i,
  output logic [1:0] set_hours_10_o,
  output logic [3:0] set_hours_1_o,
  output logic [3:0] set_minutes_10_o,
  output logic [3:0] set_minutes_1_o,
  output logic       set_valid_o,
  input  logic       set_ready_i,
  output logic       editing_o,
  output logic [3:0] blink_mask_o,
  output rtc_dbg_t   dbg_o
);
  // Load handshake: set_valid_o rises in COMMIT, holds with set_* frozen, and
  // the transfer happens on the clock edge where set_valid_o && set_ready_i.
  localparam int TO_CYC = TIMEOUT_S * CLK_HZ;
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_CYC - 1);
  localparam int BL     = CLK_HZ / 4;
  localparam int BW     = $clog2(BL + 1);
  localparam logic [BW-1:0] BL_MAX = BW'(BL - 1);

  rtc_state_e state_q, state_d;
  logic mode_lvl, mode_p, inc_lvl, inc_press, inc_p, any_p, in_edit, to_hit;
  logic [TW-1:0] to_cnt_q;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic phase_q, phase_d;
  logic [1:0] sh_h10_q;
  logic [3:0] sh_h1_q, sh_m10_q, sh_m1_q;
  logic [3:0] mask_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_mode_i), .level_o(mode_lvl), .press_o(mode_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_inc_i), .level_o(inc_lvl), .press_o(inc_press)
  );

  assign in_edit = (state_q == EDIT_H) || (state_q == EDIT_M);

`ifdef RTC_SET_AUTOREPEAT_EN
  localparam int RW = $clog2(CLK_HZ / 2 + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(CLK_HZ / 2 - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(CLK_HZ / 5 - 1);
  logic [RW-1:0] rep_cnt_q;
  logic rep_first_q, rep_p;

  assign rep_p = in_edit && inc_lvl && (rep_cnt_q == (rep_first_q ? REP_FIRST : REP_NEXT));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (!inc_lvl || !in_edit) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (rep_p) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_q + 1'b1;
    end
  end
  assign inc_p = inc_press | rep_p;
`else
  assign inc_p = inc_press;
`endif

  assign any_p  = mode_p | inc_p;
  assign to_hit = in_edit && !any_p && (to_cnt_q == TO_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (mode_p) state_d = EDIT_H;
      EDIT_H: if (mode_p) state_d = EDIT_M; else if (to_hit) state_d = IDLE;
      EDIT_M: if (mode_p) state_d = COMMIT; else if (to_hit) state_d = IDLE;
      COMMIT: if (set_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (any_p) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == BL_MAX) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
    mask_d = 4'b0000;
    if (state_d == EDIT_H) mask_d = {phase_d, phase_d, 2'b00};
    else if (state_d == EDIT_M) mask_d = {2'b00, phase_d, phase_d};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      to_cnt_q     <= '0;
      bcnt_q       <= '0;
      phase_q      <= 1'b0;
      editing_o    <= 1'b0;
      blink_mask_o <= 4'b0000;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= (in_edit && !any_p) ? to_cnt_q + 1'b1 : '0;
      bcnt_q       <= bcnt_d;
      phase_q      <= phase_d;
      editing_o    <= (state_d == EDIT_H) || (state_d == EDIT_M);
      blink_mask_o <= mask_d;
    end
  end

  // Mode beats INC in the same cycle, so INC edits only when mode_p is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_h10_q <= '0;
      sh_h1_q  <= '0;
      sh_m10_q <= '0;
      sh_m1_q  <= '0;
    end else if (state_q == IDLE && mode_p) begin
      sh_h10_q <= cur_hours_10_i;
      sh_h1_q  <= cur_hours_1_i;
      sh_m10_q <= cur_minutes_10_i;
      sh_m1_q  <= cur_minutes_1_i;
    end else if (state_q == EDIT_H && !mode_p && inc_p) begin
      {sh_h10_q, sh_h1_q} <= inc_hours(sh_h10_q, sh_h1_q);
    end else if (state_q == EDIT_M && !mode_p && inc_p) begin
      {sh_m10_q, sh_m1_q} <= inc_minutes(sh_m10_q, sh_m1_q);
    end
  end

  assign set_hours_10_o   = sh_h10_q;
  assign set_hours_1_o    = sh_h1_q;
  assign set_minutes_10_o = sh_m10_q;
  assign set_minutes_1_o  = sh_m1_q;
  assign set_valid_o      = (state_q == COMMIT);
  assign dbg_o            = '{state: state_q, mode_level: mode_lvl, inc_level: inc_lvl};
endmodule
